pc_gen: RTL

//   Parametrised program-counter generator for the fetch stage; successor to the plain PC flip-flop.
//   - Holds the fetch PC and advances it sequentially under a valid/ready handshake with fetch.
//   - Accepts redirects from trap, branch/jump resolution and a small return-address stack (RAS).
//   - Detects misaligned redirect targets and vectors them to the trap handler.

---
 rtl/pc_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: sequential advance under a valid/ready
// handshake, with trap, branch/jump and return-address-stack redirects.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(4),
  parameter int              ALIGN        = 2,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_out,
  input  logic            trap_valid,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic            ras_empty,
  output logic            misalign_trap,
  output logic [XLEN-1:0] bad_addr,
  output logic            state_dbg
);

  // Handshake: pc_out is offered whenever fetch_valid=1 and is consumed on a
  // rising edge where fetch_ready=1; without a redirect it holds until then.

  localparam int              PTR_W      = $clog2(RAS_DEPTH);
  localparam int              CNT_W      = PTR_W + 1;
  localparam logic [XLEN-1:0] STEP       = XLEN'(1) << ALIGN;
  localparam logic [XLEN-1:0] ALIGN_MASK = STEP - XLEN'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             mis_q, mis_d;
  logic [XLEN-1:0]  bad_q, bad_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             misaligned;
  logic             pop_ok;

  assign misaligned = |(redirect_target & ALIGN_MASK);
  assign pop_ok     = ras_pop && (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    bad_d   = bad_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = top_q + PTR_W'(1);
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (trap_valid) begin
      pc_d  = TRAP_VECTOR;
      cnt_d = '0;
    end else if (pop_ok && !redirect_valid) begin
      pc_d = ras_q[top_q];
      if (ras_push) begin
        // Push+pop swaps the top entry in place; depth is unchanged.
        wr_en  = 1'b1;
        wr_idx = top_q;
      end else begin
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      if (redirect_valid) begin
        if (misaligned) begin
          pc_d  = TRAP_VECTOR;
          mis_d = 1'b1;
          bad_d = redirect_target;
        end else begin
          pc_d = redirect_target;
        end
      end else if (fetch_ready) begin
        pc_d = pc_q + STEP;
      end
      if (ras_push) begin
        // At full the pointer wraps onto the oldest entry.
        wr_en = 1'b1;
        top_d = top_q + PTR_W'(1);
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      bad_q   <= '0;
      top_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) ras_q[wr_idx] <= ras_push_addr;
  end

  assign fetch_valid   = (state_q == RUN);
  assign pc_out        = pc_q;
  assign ras_empty     = (cnt_q == '0);
  assign misalign_trap = mis_q;
  assign bad_addr      = bad_q;
  assign state_dbg     = state_q;

endmodule
